// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter and its round-robin picker.
package uart_pkg;
   typedef logic [7:0] uart_byte_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DONE = 2'd1,
      HOLD      = 2'd2
   } arb_state_t;

   localparam int UART_LOCK_TIMEOUT_W = 16;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transceiver-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   import uart_pkg::*;
   localparam int IDW = id_width(N_REQ);

   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   uart_byte_t         tx_data;
   logic               tx_wr;
   logic               tx_done;
   logic [IDW-1:0]     grant_id;
   logic               busy;
   logic               lock_revoked;

   modport master (
      output req_valid, req_data, req_last, tx_done,
      input  req_ready, tx_data, tx_wr, grant_id, busy, lock_revoked
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_done,
      output req_ready, tx_data, tx_wr, grant_id, busy, lock_revoked
   );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first request after rr_ptr_i, wrapping modulo N_REQ.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDW   = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   rr_ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDW-1:0]   idx_o,
   output logic             any_req_o
);
   logic [IDW:0]   sum;
   logic [IDW-1:0] cand;

   // Walk from farthest to nearest so the nearest requester overwrites earlier hits.
   always_comb begin
      grant_o   = '0;
      idx_o     = '0;
      any_req_o = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         sum = {1'b0, rr_ptr_i} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(N_REQ)) begin
            sum = sum - (IDW+1)'(N_REQ);
         end
         cand = sum[IDW-1:0];
         if (req_i[cand]) begin
            grant_o       = '0;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
            any_req_o     = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit path between N_REQ byte sources with round-robin
// grant, packet locking and lock timeout.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int LOCK_TIMEOUT = 65535
) (
   input logic              sys_clk,
   input logic              sys_rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDW = id_width(N_REQ);
   localparam bit TIMEOUT_EN = (LOCK_TIMEOUT != 0);
   localparam logic [UART_LOCK_TIMEOUT_W-1:0] TO_LAST =
      (LOCK_TIMEOUT > 0) ? UART_LOCK_TIMEOUT_W'(LOCK_TIMEOUT - 1) : '0;

   generate
      if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
         $error("uart_tx_arbiter: N_REQ must be in 2..16");
      end
      if (LOCK_TIMEOUT < 0 || LOCK_TIMEOUT > 65535) begin : g_bad_timeout
         $error("uart_tx_arbiter: LOCK_TIMEOUT must be in 0..65535");
      end
   endgenerate

   arb_state_t                     state_q, state_d;
   logic [IDW-1:0]                 grant_q, grant_d;
   logic [IDW-1:0]                 rr_q, rr_d;
   logic                           locked_q, locked_d;
   logic [UART_LOCK_TIMEOUT_W-1:0] cnt_q, cnt_d;
   uart_byte_t                     tx_data_q, tx_data_d;
   logic                           tx_wr_q, tx_wr_d;
   logic                           revoked_q, revoked_d;

   logic [N_REQ-1:0] pick_grant;
   logic [IDW-1:0]   pick_idx;
   logic             pick_any;
   logic [N_REQ-1:0] ready;
   logic [IDW-1:0]   acc_idx;
   logic             accept;

   uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i     (bus.req_valid),
      .rr_ptr_i  (rr_q),
      .grant_o   (pick_grant),
      .idx_o     (pick_idx),
      .any_req_o (pick_any)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_q      <= IDW'(N_REQ - 1);
         locked_q  <= 1'b0;
         cnt_q     <= '0;
         tx_data_q <= '0;
         tx_wr_q   <= 1'b0;
         revoked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         locked_q  <= locked_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
         revoked_q <= revoked_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      locked_d  = locked_q;
      cnt_d     = cnt_q;
      tx_data_d = tx_data_q;
      tx_wr_d   = 1'b0;
      revoked_d = 1'b0;
      acc_idx   = (state_q == HOLD) ? grant_q : pick_idx;
      accept    = |ready;
      if (accept) begin
         tx_data_d = bus.req_data[{acc_idx, 3'b000} +: 8];
         tx_wr_d   = 1'b1;
         grant_d   = acc_idx;
         locked_d  = ~bus.req_last[acc_idx];
         cnt_d     = '0;
         state_d   = WAIT_DONE;
      end else begin
         case (state_q)
            WAIT_DONE: begin
               if (bus.tx_done) begin
                  if (locked_q) begin
                     state_d = HOLD;
                  end else begin
                     rr_d    = grant_q;
                     state_d = IDLE;
                  end
               end
            end
            HOLD: begin
               if (TIMEOUT_EN && cnt_q == TO_LAST) begin
                  revoked_d = 1'b1;
                  rr_d      = grant_q;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Ready is combinational on req_valid; the lock owner alone may be served in HOLD.
   always_comb begin
      ready = '0;
      if (!sys_rst) begin
         case (state_q)
            IDLE:    ready = pick_any ? pick_grant : '0;
            HOLD:    ready[grant_q] = bus.req_valid[grant_q];
            default: ready = '0;
         endcase
      end
   end

   assign bus.req_ready    = ready;
   assign bus.tx_data      = tx_data_q;
   assign bus.tx_wr        = tx_wr_q;
   assign bus.grant_id     = grant_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.lock_revoked = revoked_q;

   a_no_spurious_done: assert property (@(posedge sys_clk) disable iff (sys_rst)
      bus.tx_done |-> (state_q == WAIT_DONE))
      else $warning("uart_tx_arbiter: tx_done outside WAIT_DONE ignored");
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed scenarios and
// randomized traffic against a transaction-level reference model.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N  = 4;
   localparam int LT = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus.slave)
   );

   typedef struct { logic [7:0] d; bit last; } item_t;
   typedef struct { int id; logic [7:0] d; } acc_t;
   typedef struct { logic [N-1:0] valid; logic [N-1:0] ready; } vec_t;

   item_t src_q[N][$];
   acc_t  acc_q[$];
   int checks = 0;
   int errors = 0;
   logic [N-1:0] en;
   bit   force_done;
   int   x_dmin, x_dmax, x_cd;
   bit   x_pend;
   int   cyc, done_cyc, rev_cyc;

   // Reference model: arbiter is free, has a byte on the wire, or is held by an owner.
   int   m_mode, m_owner, m_ptr, m_hold_start;
   bit   m_locked;
   logic e_wr, e_rev;
   logic [7:0] e_data;
   int   e_gid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic item_t mk(input logic [7:0] d, input bit last);
      item_t it;
      it.d = d;
      it.last = last;
      return it;
   endfunction

   function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
      logic [N-1:0] r;
      r = '0;
      if (m_mode == 0) begin
         for (int k = 1; k <= N; k++) begin
            if (v[(m_ptr + k) % N]) begin
               r[(m_ptr + k) % N] = 1'b1;
               break;
            end
         end
      end else if (m_mode == 2 && v[m_owner]) begin
         r[m_owner] = 1'b1;
      end
      return r;
   endfunction

   function automatic bit pending();
      bit p;
      p = (m_mode != 0);
      for (int i = 0; i < N; i++) if (en[i] && src_q[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_owner = 0; m_ptr = N - 1; m_locked = 0; m_hold_start = 0;
      e_wr = 0; e_rev = 0; e_data = 8'h00; e_gid = 0;
      x_pend = 0; x_cd = 0; force_done = 0; en = '0;
      for (int i = 0; i < N; i++) src_q[i].delete();
      acc_q.delete();
   endtask

   task automatic step();
      logic [N-1:0] v, r;
      int w;
      acc_t a;
      v = '0;
      for (int i = 0; i < N; i++) begin
         if (en[i] && src_q[i].size() > 0) begin
            v[i] = 1'b1;
            bus.req_data[8*i +: 8] = src_q[i][0].d;
            bus.req_last[i] = src_q[i][0].last;
         end else begin
            bus.req_data[8*i +: 8] = 8'($urandom);
            bus.req_last[i] = 1'($urandom);
         end
      end
      bus.req_valid = v;
      bus.tx_done = force_done || (x_pend && x_cd == 0);
      #1;
      r = model_ready(v);
      chk("req_ready", 32'(bus.req_ready), 32'(r));
      e_wr = 0;
      e_rev = 0;
      if (r != '0) begin
         w = 0;
         for (int i = 0; i < N; i++) if (r[i]) w = i;
         e_wr = 1; e_data = src_q[w][0].d; e_gid = w;
         m_owner = w; m_locked = !src_q[w][0].last; m_mode = 1;
         a.id = w; a.d = e_data;
         acc_q.push_back(a);
         $display("accept cycle %0d req %0d data %02h last %0d", cyc, w, e_data, !m_locked);
         void'(src_q[w].pop_front());
      end else if (m_mode == 1 && bus.tx_done) begin
         done_cyc = cyc;
         if (m_locked) begin
            m_mode = 2;
            m_hold_start = cyc + 1;
         end else begin
            m_mode = 0;
            m_ptr = m_owner;
         end
      end else if (m_mode == 2 && (cyc - m_hold_start) == LT - 1) begin
         e_rev = 1; m_mode = 0; m_ptr = m_owner;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("tx_wr", 32'(bus.tx_wr), 32'(e_wr));
      chk("tx_data", 32'(bus.tx_data), 32'(e_data));
      chk("grant_id", 32'(bus.grant_id), 32'(e_gid));
      chk("busy", 32'(bus.busy), 32'(m_mode != 0));
      chk("lock_revoked", 32'(bus.lock_revoked), 32'(e_rev));
      if (bus.lock_revoked) rev_cyc = cyc;
      if (x_pend) begin
         if (x_cd == 0) x_pend = 0;
         else x_cd--;
      end
      if (bus.tx_wr) begin
         x_pend = 1;
         x_cd = $urandom_range(x_dmax, x_dmin);
      end
      force_done = 0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("drain_budget", 32'(n), 32'(budget - 1));
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      model_reset();
      bus.req_valid = '0;
      bus.tx_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      int n;
      tbl[0] = '{4'b0000, 4'b0000};
      tbl[1] = '{4'b0001, 4'b0001};
      tbl[2] = '{4'b0110, 4'b0010};
      tbl[3] = '{4'b1000, 4'b1000};
      tbl[4] = '{4'b1100, 4'b0100};
      tbl[5] = '{4'b1111, 4'b0001};
      tbl[6] = '{4'b1010, 4'b0010};

      cyc = 0; done_cyc = 0; rev_cyc = -1;
      x_dmin = 2; x_dmax = 2;
      bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_done = 1'b0;
      model_reset();

      // Reset values, with every requester asking.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = '1;
      #1;
      chk("rst_tx_wr", 32'(bus.tx_wr), 0);
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      chk("rst_grant_id", 32'(bus.grant_id), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_lock_revoked", 32'(bus.lock_revoked), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      bus.req_valid = '0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Idle-state picks right after reset: requester 0 has first priority.
      for (int t = 0; t < 7; t++) begin
         bus.req_valid = tbl[t].valid;
         #1;
         chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[t].ready));
         bus.req_valid = '0;
         @(posedge clk);
         #1;
         chk("tbl_busy", 32'(bus.busy), 0);
      end

      // Single byte from requester 2.
      src_q[2].push_back(mk(8'h41, 1'b1));
      en = 4'b0100;
      drain(50);
      chk("t1_count", 32'(acc_q.size()), 1);
      chk("t1_id", 32'(acc_q[0].id), 2);
      chk("t1_data", 32'(acc_q[0].d), 32'h41);
      chk("t1_busy", 32'(bus.busy), 0);
      chk("t1_grant_id", 32'(bus.grant_id), 2);

      // Four single-byte packets per requester pair: strict rotation.
      reset_dut();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 2; k++) src_q[i].push_back(mk(8'(16 * i + k), 1'b1));
      en = '1;
      drain(200);
      chk("t2_count", 32'(acc_q.size()), 8);
      for (int j = 0; j < 8; j++) chk("t2_rr_order", 32'(acc_q[j].id), 32'(j % 4));

      // Move the pointer to requester 0, then a locked 3-byte packet from requester 1.
      acc_q.delete();
      src_q[0].push_back(mk(8'h00, 1'b1));
      en = 4'b0001;
      drain(50);
      acc_q.delete();
      src_q[1].push_back(mk(8'h41, 1'b0));
      src_q[1].push_back(mk(8'h42, 1'b0));
      src_q[1].push_back(mk(8'h43, 1'b1));
      for (int k = 0; k < 3; k++) src_q[0].push_back(mk(8'(8'h30 + k), 1'b1));
      en = 4'b0011;
      drain(200);
      for (int j = 0; j < 3; j++) begin
         chk("t3_id", 32'(acc_q[j].id), 1);
         chk("t3_data", 32'(acc_q[j].d), 32'(8'h41 + j));
      end
      chk("t3_next_id", 32'(acc_q[3].id), 0);

      // Lock timeout: requester 3 goes silent mid-packet.
      reset_dut();
      src_q[3].push_back(mk(8'h55, 1'b0));
      src_q[0].push_back(mk(8'h30, 1'b1));
      en = 4'b1000;
      step();
      en = 4'b1001;
      rev_cyc = -1;
      n = 0;
      while (rev_cyc < 0 && n < 60) begin
         step();
         n++;
      end
      if (rev_cyc < 0) chk("t4_revoke_seen", 0, 1);
      else chk("t4_revoke_latency", 32'(rev_cyc - done_cyc), 21);
      step();
      chk("t4_grant_after_revoke", 32'(bus.grant_id), 0);
      drain(50);
      chk("t4_order", 32'(acc_q[1].id), 0);

      // Spurious tx_done in IDLE, then asynchronous reset mid-character.
      reset_dut();
      force_done = 1;
      step();
      chk("t5_spurious_busy", 32'(bus.busy), 0);
      src_q[1].push_back(mk(8'h77, 1'b1));
      en = 4'b0010;
      x_dmin = 3; x_dmax = 3;
      step();
      step();
      bus.req_valid = '1;
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_tx_wr", 32'(bus.tx_wr), 0);
      chk("t5_rst_tx_data", 32'(bus.tx_data), 0);
      chk("t5_rst_grant_id", 32'(bus.grant_id), 0);
      chk("t5_rst_busy", 32'(bus.busy), 0);
      chk("t5_rst_lock_revoked", 32'(bus.lock_revoked), 0);
      chk("t5_rst_req_ready", 32'(bus.req_ready), 0);
      model_reset();
      bus.tx_done = 1'b0;
      bus.req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].push_back(mk(8'(8'hA0 + i), 1'b1));
      en = '1;
      x_dmin = 2; x_dmax = 2;
      drain(100);
      chk("t5_first_after_reset", 32'(acc_q[0].id), 0);

      // Randomized traffic: busy phase, then sparse phase that provokes timeouts.
      x_dmin = 0; x_dmax = 3;
      for (int ph = 0; ph < 2; ph++) begin
         for (int c = 0; c < 1200; c++) begin
            for (int i = 0; i < N; i++) begin
               if (src_q[i].size() == 0 && $urandom_range(99) < 30) begin
                  n = $urandom_range(3, 1);
                  for (int b = 0; b < n; b++) src_q[i].push_back(mk(8'($urandom), b == n - 1));
               end
               en[i] = ($urandom_range(99) < ((ph == 0) ? 85 : 8));
            end
            step();
         end
      end
      en = '1;
      drain(2000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
